// File: rtl/i2c_target_rx_if.sv
// Receive-side handshake and status bundle of the I2C write target.
// master: the target that produces bytes; slave: the byte consumer.
interface i2c_target_rx_if;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addressed;
  logic       busy;
  logic       nack_sent;

  modport master (
    input  rx_ready,
    output rx_data,
    output rx_valid,
    output addressed,
    output busy,
    output nack_sent
  );

  modport slave (
    output rx_ready,
    input  rx_data,
    input  rx_valid,
    input  addressed,
    input  busy,
    input  nack_sent
  );
endinterface

// File: rtl/i2c_target_rx.sv
// I2C target receiver: oversampled SCL/SDA, START/STOP detection, 7-bit
// address match, ACK of address and data, byte delivery via valid/ready.
// Read requests are NACKed. The target only pulls SDA low or releases it.
// Optional: define I2C_TARGET_GCALL_EN to also accept the general call
// address byte 8'h00.
module i2c_target_rx #(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i2c_scl,
  inout  wire            i2c_sda,
  i2c_target_rx_if.master rx
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE
  } state_t;

  state_t              state;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                scl_prev;
  logic                sda_prev;
  logic                scl_cur;
  logic                sda_cur;
  logic                rise_q;
  logic                fall_q;
  logic                start_q;
  logic                stop_q;
  logic                sda_q;
  logic [CNT_W-1:0]    bit_cnt;
  logic [BYTE_W-1:0]   shreg;
  logic [BYTE_W-1:0]   rx_byte;
  logic                byte_ack;
  logic                sda_low;
  logic                addr_hit;
  logic [BYTE_W-1:0]   rx_data_q;
  logic                rx_valid_q;
  logic                addressed_q;
  logic                busy_q;
  logic                nack_q;

  assign i2c_sda = sda_low ? 1'b0 : 1'bz;

  assign scl_cur = scl_sync[SYNC_STAGES-1];
  assign sda_cur = sda_sync[SYNC_STAGES-1];
  assign rx_byte = {shreg[BYTE_W-2:0], sda_q};

`ifdef I2C_TARGET_GCALL_EN
  assign addr_hit = (shreg == {TARGET_ADDR, 1'b0}) || (shreg == 8'h00);
`else
  assign addr_hit = (shreg == {TARGET_ADDR, 1'b0});
`endif

  assign rx.rx_data   = rx_data_q;
  assign rx.rx_valid  = rx_valid_q;
  assign rx.addressed = addressed_q;
  assign rx.busy      = busy_q;
  assign rx.nack_sent = nack_q;

  // Synchronizers plus history flops; idle bus level is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda};
      scl_prev <= scl_cur;
      sda_prev <= sda_cur;
    end
  end

  // Registered bus events; SCL must be high on both samples for START/STOP
  // so an SDA change coinciding with an SCL fall is not mistaken for one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      sda_q   <= 1'b1;
    end else begin
      rise_q  <= !scl_prev && scl_cur;
      fall_q  <= scl_prev && !scl_cur;
      start_q <= scl_prev && scl_cur && sda_prev && !sda_cur;
      stop_q  <= scl_prev && scl_cur && !sda_prev && sda_cur;
      sda_q   <= sda_cur;
    end
  end

  // Protocol FSM with registered outputs; START/STOP override bit handling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      byte_ack    <= 1'b0;
      sda_low     <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      addressed_q <= 1'b0;
      busy_q      <= 1'b0;
      nack_q      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      nack_q     <= 1'b0;
      if (start_q) begin
        state       <= ADDR;
        bit_cnt     <= '0;
        sda_low     <= 1'b0;
        busy_q      <= 1'b1;
        addressed_q <= 1'b0;
      end else if (stop_q) begin
        state       <= IDLE;
        sda_low     <= 1'b0;
        busy_q      <= 1'b0;
        addressed_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sda_low <= 1'b0;
          end
          ADDR: begin
            if (rise_q && (bit_cnt < CNT_W'(8))) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + CNT_W'(1);
            end else if (fall_q && (bit_cnt == CNT_W'(8))) begin
              if (addr_hit) begin
                sda_low <= 1'b1;
                state   <= ADDR_ACK;
              end else begin
                state   <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (fall_q) begin
              sda_low     <= 1'b0;
              addressed_q <= 1'b1;
              bit_cnt     <= '0;
              state       <= DATA;
            end
          end
          DATA: begin
            if (rise_q && (bit_cnt < CNT_W'(8))) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(7)) begin
                if (rx.rx_ready) begin
                  rx_data_q  <= rx_byte;
                  rx_valid_q <= 1'b1;
                  byte_ack   <= 1'b1;
                end else begin
                  nack_q     <= 1'b1;
                  byte_ack   <= 1'b0;
                end
              end
            end else if (fall_q && (bit_cnt == CNT_W'(8))) begin
              if (byte_ack) begin
                sda_low <= 1'b1;
                state   <= DATA_ACK;
              end else begin
                sda_low <= 1'b0;
                state   <= IGNORE;
              end
            end
          end
          DATA_ACK: begin
            if (fall_q) begin
              sda_low <= 1'b0;
              bit_cnt <= '0;
              state   <= DATA;
            end
          end
          IGNORE: begin
            sda_low <= 1'b0;
          end
          default: begin
            sda_low <= 1'b0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: a bit-banged bus master, a byte
// scoreboard fed as bytes are sent and drained when rx_valid pulses.
module tb_i2c_target_rx;

  localparam int Q = 5;

  logic clk;
  logic reset;
  logic scl;
  logic m_sda_low;
  wire  sda;

  int checks;
  int errors;
  int valid_cnt;
  int nack_cnt;
  logic track_busy;
  logic busy_drop;
  logic [7:0] exp_q[$];

  i2c_target_rx_if rx ();

  i2c_target_rx #(.TARGET_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .i2c_scl (scl),
    .i2c_sda (sda),
    .rx      (rx.master)
  );

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = !b;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(2 * Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic ack_bit(output logic a);
    m_sda_low = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    a = sda;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    ack_bit(a);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b1;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic bus_rstart();
    m_sda_low = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    m_sda_low = 1'b1;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    m_sda_low = 1'b0;
    wait_clk(Q);
  endtask

  // Scoreboard drain and pulse bookkeeping.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx.rx_valid === 1'b1) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL rx_valid_unexpected observed=%0h expected=none", rx.rx_data);
        end else begin
          check("rx_data", rx.rx_data, exp_q.pop_front());
        end
      end
      if (rx.nack_sent === 1'b1) nack_cnt++;
      if (track_busy && rx.busy !== 1'b1) busy_drop = 1'b1;
    end
  end

  initial begin
    logic a;
    int v0, n0;
    checks = 0; errors = 0; valid_cnt = 0; nack_cnt = 0;
    track_busy = 1'b0; busy_drop = 1'b0;
    scl = 1'b1; m_sda_low = 1'b0; rx.rx_ready = 1'b1;
    reset = 1'b1;
    wait_clk(4);
    check("reset_rx_data", rx.rx_data, 8'h00);
    check("reset_rx_valid", 8'(rx.rx_valid), 8'h0);
    check("reset_addressed", 8'(rx.addressed), 8'h0);
    check("reset_busy", 8'(rx.busy), 8'h0);
    check("reset_nack", 8'(rx.nack_sent), 8'h0);
    check("reset_sda", 8'(sda), 8'h1);
    reset = 1'b0;
    wait_clk(4);

    // Write 0x50 / 0xA5 with ACK latency probe on the address byte.
    v0 = valid_cnt;
    bus_start();
    check("t1_busy", 8'(rx.busy), 8'h1);
    for (int i = 7; i >= 1; i--) send_bit(logic'((8'hA0 >> i) & 8'h01));
    m_sda_low = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(2 * Q);
    scl = 1'b0;
    m_sda_low = 1'b0;
    wait_clk(3);
    check("t1_ack_not_yet", 8'(sda), 8'h1);
    wait_clk(1);
    check("t1_ack_driven", 8'(sda), 8'h0);
    wait_clk(Q - 4);
    ack_bit(a);
    check("t1_addr_ack", 8'(a), 8'h0);
    check("t1_addressed", 8'(rx.addressed), 8'h1);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, a);
    check("t1_data_ack", 8'(a), 8'h0);
    check("t1_busy_before_stop", 8'(rx.busy), 8'h1);
    bus_stop();
    check("t1_busy_after_stop", 8'(rx.busy), 8'h0);
    check("t1_addressed_after_stop", 8'(rx.addressed), 8'h0);
    check("t1_valid_count", 8'(valid_cnt - v0), 8'd1);

    // Write to foreign address 0x51.
    v0 = valid_cnt;
    bus_start();
    send_byte(8'hA2, a);
    check("t2_addr_nack", 8'(a), 8'h1);
    send_byte(8'h3C, a);
    check("t2_data_nack", 8'(a), 8'h1);
    check("t2_addressed", 8'(rx.addressed), 8'h0);
    bus_stop();
    check("t2_valid_count", 8'(valid_cnt - v0), 8'd0);

    // Read request to own address.
    v0 = valid_cnt;
    bus_start();
    send_byte(8'hA1, a);
    check("t3_addr_nack", 8'(a), 8'h1);
    send_byte(8'h55, a);
    check("t3_data_nack", 8'(a), 8'h1);
    check("t3_busy", 8'(rx.busy), 8'h1);
    bus_stop();
    check("t3_valid_count", 8'(valid_cnt - v0), 8'd0);

    // Three bytes, consumer not ready at the second.
    v0 = valid_cnt; n0 = nack_cnt;
    bus_start();
    send_byte(8'hA0, a);
    check("t4_addr_ack", 8'(a), 8'h0);
    exp_q.push_back(8'h11);
    send_byte(8'h11, a);
    check("t4_b1_ack", 8'(a), 8'h0);
    rx.rx_ready = 1'b0;
    send_byte(8'h22, a);
    check("t4_b2_nack", 8'(a), 8'h1);
    rx.rx_ready = 1'b1;
    send_byte(8'h33, a);
    check("t4_b3_nack", 8'(a), 8'h1);
    bus_stop();
    check("t4_valid_count", 8'(valid_cnt - v0), 8'd1);
    check("t4_nack_count", 8'(nack_cnt - n0), 8'd1);

    // Repeated START between two writes.
    v0 = valid_cnt;
    bus_start();
    track_busy = 1'b1;
    send_byte(8'hA0, a);
    check("t5_addr1_ack", 8'(a), 8'h0);
    exp_q.push_back(8'h11);
    send_byte(8'h11, a);
    check("t5_b1_ack", 8'(a), 8'h0);
    bus_rstart();
    check("t5_addressed_after_rs", 8'(rx.addressed), 8'h0);
    send_byte(8'hA0, a);
    check("t5_addr2_ack", 8'(a), 8'h0);
    exp_q.push_back(8'h99);
    send_byte(8'h99, a);
    check("t5_b2_ack", 8'(a), 8'h0);
    track_busy = 1'b0;
    bus_stop();
    check("t5_valid_count", 8'(valid_cnt - v0), 8'd2);
    check("t5_busy_held", 8'(busy_drop), 8'h0);

    // Reset while the target drives the address ACK.
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(logic'((8'hA0 >> i) & 8'h01));
    m_sda_low = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(1);
    check("t6_ack_before_reset", 8'(sda), 8'h0);
    reset = 1'b1;
    #1;
    check("t6_sda_released", 8'(sda), 8'h1);
    check("t6_busy", 8'(rx.busy), 8'h0);
    check("t6_addressed", 8'(rx.addressed), 8'h0);
    check("t6_rx_valid", 8'(rx.rx_valid), 8'h0);
    wait_clk(3);
    scl = 1'b0;
    wait_clk(Q);
    reset = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    check("t6_idle_busy", 8'(rx.busy), 8'h0);
    v0 = valid_cnt;
    bus_start();
    send_byte(8'hA0, a);
    check("t6_addr_ack", 8'(a), 8'h0);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, a);
    check("t6_data_ack", 8'(a), 8'h0);
    bus_stop();
    check("t6_valid_count", 8'(valid_cnt - v0), 8'd1);

    // General call address.
    v0 = valid_cnt;
    bus_start();
    send_byte(8'h00, a);
`ifdef I2C_TARGET_GCALL_EN
    check("t7_gcall_ack", 8'(a), 8'h0);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, a);
    check("t7_gcall_data_ack", 8'(a), 8'h0);
    bus_stop();
    check("t7_valid_count", 8'(valid_cnt - v0), 8'd1);
`else
    check("t7_gcall_nack", 8'(a), 8'h1);
    send_byte(8'h5A, a);
    check("t7_gcall_data_nack", 8'(a), 8'h1);
    bus_stop();
    check("t7_valid_count", 8'(valid_cnt - v0), 8'd0);
`endif

    wait_clk(10);
    check("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
